// File: rtl/obstacle_field_ctrl.sv
// Obstacle-field game engine: scrolling rows with one random gap each, a steerable
// player block, run/pause/over control, collision detection, score and level/speed.
module obstacle_field_ctrl #(
  parameter int NUM_ROWS    = 5,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int H_RES       = 1280,
  parameter int V_RES       = 1024,
  parameter int ROW_H       = 20,
  parameter int ROW_SPACING = 200,
  parameter int GAP_W       = 160,
  parameter int PLAYER_W    = 32,
  parameter int PLAYER_Y    = 900,
  parameter int PLAYER_STEP = 4,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 8,
  parameter int LEVEL_ROWS  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    left,
  input  logic                    right,
  output logic [X_W-1:0]          player_x,
  output logic [NUM_ROWS*Y_W-1:0] row_y,
  output logic [NUM_ROWS*X_W-1:0] gap_left,
  output logic [1:0]              state,
  output logic [3:0]              level,
  output logic [15:0]             score,
  output logic                    hit
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;
  typedef logic [X_W:0] xw_t;
  typedef logic [Y_W:0] yw_t;

  localparam int             GAP_MAX   = H_RES - GAP_W;
  localparam int             PX_MAX    = H_RES - PLAYER_W;
  localparam logic [X_W-1:0] PX_INIT   = X_W'(PX_MAX / 2);
  localparam logic [X_W-1:0] GAP_INIT  = X_W'(GAP_MAX / 2);
  localparam logic [15:0]    LFSR_SEED = 16'hACE1;

  function automatic logic [Y_W-1:0] row_init(input int i);
    return Y_W'(ROW_SPACING * (i + 1));
  endfunction

  state_t         st_q, st_d;
  logic [X_W-1:0] px_q, px_d;
  logic [Y_W-1:0] row_q [NUM_ROWS];
  logic [Y_W-1:0] row_d [NUM_ROWS];
  logic [X_W-1:0] gap_q [NUM_ROWS];
  logic [X_W-1:0] gap_d [NUM_ROWS];
  logic [3:0]     level_d;
  logic [15:0]    score_d;
  logic           hit_d;
  logic [15:0]    lfsr_q;
  logic           start_q, pause_q;
  logic           start_edge, pause_edge;

  // Candidate values for one tick of motion; committed only on tick in RUN.
  logic [Y_W-1:0] mv_row [NUM_ROWS];
  logic [X_W-1:0] mv_gap [NUM_ROWS];
  logic [X_W-1:0] mv_px;
  logic [3:0]     mv_level;
  logic [15:0]    mv_score;
  logic           collide;
  logic [7:0]     spd_sum;
  yw_t            spd;
  xw_t            gap_c;
  xw_t            px_sum;
  logic [3:0]     wraps;
  logic [16:0]    score_sum;
  logic [16:0]    lvl_sum;

  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    spd_sum = 8'(SPEED_INIT) + {4'd0, level};
    spd     = (spd_sum > 8'(SPEED_MAX)) ? yw_t'(SPEED_MAX) : yw_t'(spd_sum);
    wraps   = '0;
    gap_c   = '0;
    collide = 1'b0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      mv_gap[i] = gap_q[i];
      if ({1'b0, row_q[i]} >= spd) begin
        mv_row[i] = Y_W'({1'b0, row_q[i]} - spd);
      end else begin
        // Wrap to the bottom and draw a fresh gap from the LFSR.
        mv_row[i] = Y_W'({1'b0, row_q[i]} + yw_t'(V_RES) - spd);
        gap_c     = {1'b0, lfsr_q[X_W-1:0]} + xw_t'(37 * i);
        if (gap_c > xw_t'(GAP_MAX)) gap_c = gap_c - xw_t'(GAP_MAX + 1);
        mv_gap[i] = X_W'(gap_c);
        wraps     = wraps + 4'd1;
      end
    end

    px_sum = {1'b0, px_q} + xw_t'(PLAYER_STEP);
    mv_px  = px_q;
    if (left && !right) begin
      mv_px = ({1'b0, px_q} >= xw_t'(PLAYER_STEP)) ? X_W'({1'b0, px_q} - xw_t'(PLAYER_STEP)) : '0;
    end else if (right && !left) begin
      mv_px = (px_sum > xw_t'(PX_MAX)) ? X_W'(PX_MAX) : X_W'(px_sum);
    end

    for (int i = 0; i < NUM_ROWS; i++) begin
      if (({1'b0, mv_row[i]} < yw_t'(PLAYER_Y + PLAYER_W)) &&
          ({1'b0, mv_row[i]} + yw_t'(ROW_H) > yw_t'(PLAYER_Y)) &&
          (({1'b0, mv_px} < {1'b0, mv_gap[i]}) ||
           ({1'b0, mv_px} + xw_t'(PLAYER_W) > {1'b0, mv_gap[i]} + xw_t'(GAP_W))))
        collide = 1'b1;
    end

    score_sum = {1'b0, score} + 17'(wraps);
    mv_score  = (score_sum > 17'h0FFFF) ? 16'hFFFF : score_sum[15:0];
    // Levels gained = multiples of LEVEL_ROWS crossed by this tick's score change.
    lvl_sum   = 17'(level) + 17'(mv_score / 16'(LEVEL_ROWS)) - 17'(score / 16'(LEVEL_ROWS));
    mv_level  = (lvl_sum > 17'd15) ? 4'd15 : lvl_sum[3:0];
  end

  always_comb begin
    st_d    = st_q;
    px_d    = px_q;
    row_d   = row_q;
    gap_d   = gap_q;
    level_d = level;
    score_d = score;
    hit_d   = 1'b0;
    unique case (st_q)
      IDLE: if (start_edge) begin
        st_d    = RUN;
        px_d    = PX_INIT;
        level_d = '0;
        score_d = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
          row_d[i] = row_init(i);
          gap_d[i] = GAP_INIT;
        end
      end
      RUN: if (pause_edge) begin
        st_d = PAUSE;
      end else if (tick) begin
        px_d    = mv_px;
        row_d   = mv_row;
        gap_d   = mv_gap;
        level_d = mv_level;
        score_d = mv_score;
        if (collide) begin
          st_d  = OVER;
          hit_d = 1'b1;
        end
      end
      PAUSE: if (pause_edge) st_d = RUN;
      OVER:  if (start_edge) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // NOTE: the row/gap arrays are a handful of flops, not RAM, so they take the reset too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= IDLE;
      px_q    <= PX_INIT;
      level   <= '0;
      score   <= '0;
      hit     <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        row_q[i] <= row_init(i);
        gap_q[i] <= GAP_INIT;
      end
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      st_q    <= st_d;
      px_q    <= px_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      level   <= level_d;
      score   <= score_d;
      hit     <= hit_d;
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      start_q <= start;
      pause_q <= pause;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ROWS; i++) begin
      row_y[i*Y_W +: Y_W]    = row_q[i];
      gap_left[i*X_W +: X_W] = gap_q[i];
    end
  end

  assign player_x = px_q;
  assign state    = st_q;

endmodule

// File: tb/tb_obstacle_field_ctrl.sv
// Scoreboard bench for obstacle_field_ctrl: a behavioural game model predicts every
// cycle's outputs, which are queued at drive time and compared once the DUT updates.
module tb_obstacle_field_ctrl;
  localparam int NR = 5;

  logic clk = 1'b0, rst = 1'b0;
  logic tick = 1'b0, start = 1'b0, pause = 1'b0, left = 1'b0, right = 1'b0;
  logic [10:0] player_x;
  logic [49:0] row_y;
  logic [54:0] gap_left;
  logic [1:0]  state;
  logic [3:0]  level;
  logic [15:0] score;
  logic        hit;

  always #5 clk = ~clk;

  obstacle_field_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
    .left(left), .right(right), .player_x(player_x), .row_y(row_y),
    .gap_left(gap_left), .state(state), .level(level), .score(score), .hit(hit)
  );

  typedef struct packed {
    logic [10:0] px;
    logic [49:0] rows;
    logic [54:0] gaps;
    logic [1:0]  st;
    logic [3:0]  lvl;
    logic [15:0] sc;
    logic        hit;
  } snap_t;

  snap_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference model of the game.
  int          m_st, m_px, m_level, m_score;
  int          m_row [NR];
  int          m_gap [NR];
  bit          m_hit, m_sq, m_pq;
  logic [15:0] m_lfsr;

  task automatic model_load();
    m_px = 624; m_level = 0; m_score = 0;
    for (int i = 0; i < NR; i++) begin
      m_row[i] = 200 * (i + 1);
      m_gap[i] = 560;
    end
  endtask

  task automatic model_reset();
    model_load();
    m_st = 0; m_hit = 0; m_lfsr = 16'hACE1; m_sq = 0; m_pq = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit p, input bit l, input bit r);
    bit se, pe, col;
    int spd, wraps, c, npx, ns, nl;
    int nrow [NR];
    int ngap [NR];
    se = s && !m_sq;
    pe = p && !m_pq;
    m_hit = 0;
    case (m_st)
      0: if (se) begin model_load(); m_st = 1; end
      1: if (pe) m_st = 2;
         else if (t) begin
           spd = (m_level + 1 > 8) ? 8 : m_level + 1;
           wraps = 0;
           for (int i = 0; i < NR; i++) begin
             ngap[i] = m_gap[i];
             if (m_row[i] >= spd) nrow[i] = m_row[i] - spd;
             else begin
               nrow[i] = m_row[i] + 1024 - spd;
               c = int'(m_lfsr[10:0]) + 37 * i;
               if (c > 1120) c = c - 1121;
               ngap[i] = c;
               wraps++;
             end
           end
           npx = m_px;
           if (l && !r) npx = (m_px - 4 < 0) ? 0 : m_px - 4;
           if (r && !l) npx = (m_px + 4 > 1248) ? 1248 : m_px + 4;
           col = 0;
           for (int i = 0; i < NR; i++)
             if (nrow[i] < 932 && nrow[i] + 20 > 900 && (npx < ngap[i] || npx + 32 > ngap[i] + 160))
               col = 1;
           ns = (m_score + wraps > 65535) ? 65535 : m_score + wraps;
           nl = m_level + ns / 8 - m_score / 8;
           m_level = (nl > 15) ? 15 : nl;
           m_score = ns;
           m_px = npx;
           for (int i = 0; i < NR; i++) begin
             m_row[i] = nrow[i];
             m_gap[i] = ngap[i];
           end
           if (col) begin m_st = 3; m_hit = 1; end
         end
      2: if (pe) m_st = 1;
      default: if (se) m_st = 0;
    endcase
    m_sq = s;
    m_pq = p;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  function automatic snap_t model_snap();
    snap_t e;
    e.px = 11'(m_px);
    for (int i = 0; i < NR; i++) begin
      e.rows[i*10 +: 10] = 10'(m_row[i]);
      e.gaps[i*11 +: 11] = 11'(m_gap[i]);
    end
    e.st = 2'(m_st); e.lvl = 4'(m_level); e.sc = 16'(m_score); e.hit = m_hit;
    return e;
  endfunction

  function automatic logic [49:0] rows_minus(input int off);
    logic [49:0] v;
    for (int i = 0; i < NR; i++) v[i*10 +: 10] = 10'(200 * (i + 1) - off);
    return v;
  endfunction

  function automatic logic [54:0] gaps_all(input int g);
    logic [54:0] v;
    for (int i = 0; i < NR; i++) v[i*11 +: 11] = 11'(g);
    return v;
  endfunction

  // One clock: drive inputs, queue the model's prediction, compare after the edge.
  task automatic drive(input bit t, input bit s, input bit p, input bit l, input bit r);
    snap_t e;
    tick = t; start = s; pause = p; left = l; right = r;
    model_step(t, s, p, l, r);
    exp_q.push_back(model_snap());
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("sb_player_x", 64'(player_x), 64'(e.px));
    check("sb_row_y",    64'(row_y),    64'(e.rows));
    check("sb_gap_left", 64'(gap_left), 64'(e.gaps));
    check("sb_state",    64'(state),    64'(e.st));
    check("sb_level",    64'(level),    64'(e.lvl));
    check("sb_score",    64'(score),    64'(e.sc));
    check("sb_hit",      64'(hit),      64'(e.hit));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row_y"},    64'(row_y),    64'(rows_minus(0)));
    check({tag, "_gap_left"}, 64'(gap_left), 64'(gaps_all(560)));
    check({tag, "_player_x"}, 64'(player_x), 64'd624);
    check({tag, "_level"},    64'(level),    64'd0);
    check({tag, "_score"},    64'(score),    64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t snap;
    int k;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    check("reset_state", 64'(state), 64'd0);
    check("reset_hit",   64'(hit),   64'd0);
    rst = 1'b1;

    // Idle: ticks without start do nothing.
    repeat (10) drive(1, 0, 0, 0, 0);
    check_reset_vals("idle");
    check("idle_state", 64'(state), 64'd0);

    // Start and scroll three ticks.
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0);
    check("run_state", 64'(state), 64'd1);
    check("scroll_rows", 64'(row_y), 64'(rows_minus(3)));
    check("scroll_score", 64'(score), 64'd0);

    // A start edge while running is ignored.
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("start_in_run", 64'(state), 64'd1);

    // Up to tick 119 row 4 crosses the player band over the initial gap.
    repeat (116) drive(1, 0, 0, 0, 0);
    repeat (5) drive(1, 0, 0, 1, 1);
    check("both_hold", 64'(player_x), 64'd624);

    // Ticks 125..201 steering left; tick 201 wraps row 0.
    repeat (76) drive(1, 0, 0, 1, 0);
    check("row0_at_zero", 64'(row_y[9:0]), 64'd0);
    drive(1, 0, 0, 1, 0);
    check("wrap_row0", 64'(row_y[9:0]), 64'd1023);
    check("wrap_score", 64'(score), 64'd1);
    check("wrap_gap_range", 64'(gap_left[10:0] <= 11'd1120), 64'd1);
    check("wrap_gap_lfsr", 64'(gap_left[10:0]), 64'(m_gap[0]));

    repeat (84) drive(1, 0, 0, 1, 0);
    check("left_clamp", 64'(player_x), 64'd0);

    // Let a freshly gapped row reach the player.
    k = 0;
    while (m_st != 3 && k < 2000) begin
      drive(1, 0, 0, 0, 0);
      k++;
    end
    check("collision_reached", 64'(k < 2000), 64'd1);
    check("collide_state", 64'(state), 64'd3);
    check("collide_hit", 64'(hit), 64'd1);
    snap = model_snap();
    drive(1, 0, 0, 0, 0);
    check("hit_one_cycle", 64'(hit), 64'd0);
    repeat (4) drive(1, 0, 0, 1, 0);
    check("over_frozen_rows", 64'(row_y), 64'(snap.rows));
    check("over_frozen_px", 64'(player_x), 64'(snap.px));
    check("over_state", 64'(state), 64'd3);

    // OVER -> IDLE -> RUN needs two start edges.
    drive(0, 1, 0, 0, 0);
    check("over_to_idle", 64'(state), 64'd0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("restart_state", 64'(state), 64'd1);
    check_reset_vals("restart");
    drive(0, 0, 0, 0, 0);

    // Pause: ticks ignored, pause+tick in one cycle means no motion.
    repeat (10) drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    check("pause_state", 64'(state), 64'd2);
    drive(0, 0, 0, 0, 0);
    snap = model_snap();
    repeat (5) drive(1, 0, 0, 1, 0);
    check("pause_rows_hold", 64'(row_y), 64'(snap.rows));
    check("pause_px_hold", 64'(player_x), 64'(snap.px));
    drive(0, 0, 1, 0, 0);
    check("resume_state", 64'(state), 64'd1);
    drive(0, 0, 0, 0, 0);
    snap = model_snap();
    drive(1, 0, 1, 0, 0);
    check("pause_tick_state", 64'(state), 64'd2);
    check("pause_tick_rows", 64'(row_y), 64'(snap.rows));
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Right clamp once row 4 has cleared the player band.
    k = 0;
    while (m_row[4] > 880 && k < 500) begin
      drive(1, 0, 0, 0, 0);
      k++;
    end
    repeat (160) drive(1, 0, 0, 0, 1);
    check("right_clamp", 64'(player_x), 64'd1248);
    check("right_clamp_state", 64'(state), 64'd1);

    // Asynchronous reset mid-run, checked before any further clock edge.
    tick = 0; start = 0; pause = 0; left = 0; right = 0;
    #1 rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    check("async_rst_state", 64'(state), 64'd0);
    check("async_rst_hit", 64'(hit), 64'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0);
    check("post_rst_scroll", 64'(row_y), 64'(rows_minus(3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
